rb_param: RTL and testbench

- Parametrised successor to the team's 16x32 register bank.
- Adds configurable width and depth, optional hard-wired zero register and write-to-read bypass.
- Adds a per-register busy scoreboard: reads of a register with a pending write stall until that write lands.
- Sits between decode (read and reserve requests) and writeback (write port) of the MIPS32 core. Keeps the two debug tap outputs used by the board display.

---
 rtl/rb_pkg.sv | 36 +++
 rtl/rb_scoreboard.sv | 73 +++++++
 rtl/rb_param.sv | 131 +++++++++++++
 tb/tb_rb_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared defaults and read-source encoding for the parametrised register bank.
// Imported by rb_param and rb_scoreboard.
package rb_pkg;

  localparam int RB_DATA_W   = 32;
  localparam int RB_ADDR_W   = 4;
  localparam int RB_TAP0_IDX = 10;
  localparam int RB_TAP1_IDX = 3;
  localparam int RB_TAP_W    = 8;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_ARRAY  = 2'd2
  } rd_src_e;

  // Hard-wired zero beats forwarding, forwarding beats the stored value.
  function automatic rd_src_e rd_src_sel(
    input logic i_zero_r0,
    input logic i_bypass,
    input logic i_write,
    input logic i_addr_is_zero,
    input logic i_addr_hit
  );
    rd_src_e v_src;
    if (i_zero_r0 && i_addr_is_zero) begin
      v_src = SRC_ZERO;
    end else if (i_bypass && i_write && i_addr_hit) begin
      v_src = SRC_BYPASS;
    end else begin
      v_src = SRC_ARRAY;
    end
    return v_src;
  endfunction

endpackage

// File: rtl/rb_scoreboard.sv
// Per-register busy scoreboard: reserve sets, write clears (reserve wins),
// and a same-cycle write can hide a busy bit from the stall check when bypassing.
module rb_scoreboard import rb_pkg::*; #(
  parameter int ADDR_W  = RB_ADDR_W,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic                   i_write,
  input  logic [ADDR_W-1:0]      i_rd,
  input  logic                   i_reserve,
  input  logic [ADDR_W-1:0]      i_rsv_addr,
  input  logic                   i_read,
  input  logic [ADDR_W-1:0]      i_rs,
  input  logic [ADDR_W-1:0]      i_rt,
  output logic [2**ADDR_W-1:0]   o_busy,
  output logic                   o_stall
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_wr_hit;
  logic [NREG-1:0] w_rsv_hit;
  logic [NREG-1:0] w_beff;
  logic [NREG-1:0] w_busy_nxt;

  // Decode write/reserve addresses, masking R0 when it is hard-wired.
  always_comb begin
    w_wr_hit  = '0;
    w_rsv_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ZERO_R0 && (ADDR_W'(i) == '0)) begin
        w_wr_hit[i]  = 1'b0;
        w_rsv_hit[i] = 1'b0;
      end else begin
        w_wr_hit[i]  = i_write && (i_rd == ADDR_W'(i));
        w_rsv_hit[i] = i_reserve && (i_rsv_addr == ADDR_W'(i));
      end
    end
  end

  // Effective busy and next-state busy.
  always_comb begin
    w_beff     = '0;
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREG; i++) begin
      w_beff[i] = r_busy[i] && !(BYPASS && w_wr_hit[i]);
      if (i_enable && w_rsv_hit[i]) begin
        w_busy_nxt[i] = 1'b1;
      end else if (i_enable && w_wr_hit[i]) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy  = r_busy;
  assign o_stall = i_enable && i_read && (w_beff[i_rs] || w_beff[i_rt]);

endmodule

// File: rtl/rb_param.sv
// Parametrised register bank with busy scoreboard, optional zero register,
// write-to-read forwarding and two debug taps for the board display.
module rb_param import rb_pkg::*; #(
  parameter int DATA_W   = RB_DATA_W,
  parameter int ADDR_W   = RB_ADDR_W,
  parameter bit ZERO_R0  = 1'b0,
  parameter bit BYPASS   = 1'b1,
  parameter int TAP0_IDX = RB_TAP0_IDX,
  parameter int TAP1_IDX = RB_TAP1_IDX,
  parameter int TAP_W    = RB_TAP_W
) (
  input  logic                  clk,
  input  logic                  reset_all,
  input  logic                  enable,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     rs,
  input  logic [ADDR_W-1:0]     rt,
  output logic [DATA_W-1:0]     out1,
  output logic [DATA_W-1:0]     out2,
  output logic                  rd_valid,
  output logic                  rd_stall,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     rd,
  input  logic [DATA_W-1:0]     in1,
  input  logic                  reserve,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [TAP_W-1:0]      out,
  output logic [TAP_W-1:0]      outt
);

  localparam int NREG = 2**ADDR_W;

  if (TAP0_IDX < 0 || TAP0_IDX >= NREG || TAP1_IDX < 0 || TAP1_IDX >= NREG
      || TAP_W > DATA_W) begin : g_param_err
    $error("rb_param: tap index or tap width out of range");
  end

  localparam logic [ADDR_W-1:0] LP_TAP0 = ADDR_W'(TAP0_IDX);
  localparam logic [ADDR_W-1:0] LP_TAP1 = ADDR_W'(TAP1_IDX);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_out1;
  logic [DATA_W-1:0] r_out2;
  logic              r_rd_valid;
  logic [DATA_W-1:0] w_rdata1;
  logic [DATA_W-1:0] w_rdata2;
  logic              w_stall;
  logic              w_wr_en;
  logic              w_rd_acc;
  rd_src_e           w_src1;
  rd_src_e           w_src2;

  rb_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (reset_all),
    .i_enable   (enable),
    .i_write    (write),
    .i_rd       (rd),
    .i_reserve  (reserve),
    .i_rsv_addr (rsv_addr),
    .i_read     (read),
    .i_rs       (rs),
    .i_rt       (rt),
    .o_busy     (busy),
    .o_stall    (w_stall)
  );

  assign w_wr_en  = enable && write && !(ZERO_R0 && (rd == '0));
  assign w_rd_acc = enable && read && !w_stall;

  // Read-source selection for both ports.
  always_comb begin
    w_src1 = rd_src_sel(ZERO_R0, BYPASS, write, (rs == '0), (rs == rd));
    w_src2 = rd_src_sel(ZERO_R0, BYPASS, write, (rt == '0), (rt == rd));
  end

  // Read data muxes.
  always_comb begin
    case (w_src1)
      SRC_ZERO:   w_rdata1 = '0;
      SRC_BYPASS: w_rdata1 = in1;
      SRC_ARRAY:  w_rdata1 = r_regs[rs];
      default:    w_rdata1 = r_regs[rs];
    endcase
    case (w_src2)
      SRC_ZERO:   w_rdata2 = '0;
      SRC_BYPASS: w_rdata2 = in1;
      SRC_ARRAY:  w_rdata2 = r_regs[rt];
      default:    w_rdata2 = r_regs[rt];
    endcase
  end

  // Storage array; every entry is cleared on reset.
  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[rd] <= in1;
    end
  end

  // Registered read ports and one-shot valid.
  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      r_out1     <= '0;
      r_out2     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_out1 <= w_rdata1;
        r_out2 <= w_rdata2;
      end
    end
  end

  assign out1     = r_out1;
  assign out2     = r_out2;
  assign rd_valid = r_rd_valid;
  assign rd_stall = w_stall;
  assign out      = r_regs[LP_TAP0][TAP_W-1:0];
  assign outt     = r_regs[LP_TAP1][TAP_W-1:0];

endmodule

// File: tb/tb_rb_param.sv
// Bench for rb_param: three configurations (default, no bypass, zero R0) share
// one stimulus stream and are compared against a per-configuration reference model.
module tb_rb_param;

  logic        clk = 1'b0;
  logic        reset_all;
  logic        enable, read, write, reserve;
  logic [3:0]  rs, rt, rd, rsv_addr;
  logic [31:0] in1;

  logic [31:0] o1 [3];
  logic [31:0] o2 [3];
  logic        v  [3];
  logic        st [3];
  logic [15:0] bz [3];
  logic [7:0]  tp0 [3];
  logic [7:0]  tp1 [3];

  always #5 clk = ~clk;

  rb_param u_dut0 (
    .clk(clk), .reset_all(reset_all), .enable(enable), .read(read), .rs(rs), .rt(rt),
    .out1(o1[0]), .out2(o2[0]), .rd_valid(v[0]), .rd_stall(st[0]), .write(write), .rd(rd),
    .in1(in1), .reserve(reserve), .rsv_addr(rsv_addr), .busy(bz[0]), .out(tp0[0]), .outt(tp1[0])
  );

  rb_param #(.BYPASS(1'b0)) u_dut1 (
    .clk(clk), .reset_all(reset_all), .enable(enable), .read(read), .rs(rs), .rt(rt),
    .out1(o1[1]), .out2(o2[1]), .rd_valid(v[1]), .rd_stall(st[1]), .write(write), .rd(rd),
    .in1(in1), .reserve(reserve), .rsv_addr(rsv_addr), .busy(bz[1]), .out(tp0[1]), .outt(tp1[1])
  );

  rb_param #(.ZERO_R0(1'b1)) u_dut2 (
    .clk(clk), .reset_all(reset_all), .enable(enable), .read(read), .rs(rs), .rt(rt),
    .out1(o1[2]), .out2(o2[2]), .rd_valid(v[2]), .rd_stall(st[2]), .write(write), .rd(rd),
    .in1(in1), .reserve(reserve), .rsv_addr(rsv_addr), .busy(bz[2]), .out(tp0[2]), .outt(tp1[2])
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one copy per configuration.
  logic [31:0] m_regs [3][16];
  logic [15:0] m_busy [3];
  logic [31:0] m_o1 [3];
  logic [31:0] m_o2 [3];
  logic        m_v  [3];
  logic        last_st [3];

  function automatic bit zr(input int k);
    return (k == 2);
  endfunction

  function automatic bit bp(input int k);
    return (k != 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_blocked(input int k, input logic [3:0] a);
    bit wr_hit;
    wr_hit = write && (rd == a) && !(zr(k) && a == 4'd0);
    return m_busy[k][a] && !(bp(k) && wr_hit);
  endfunction

  function automatic logic [31:0] m_value(input int k, input logic [3:0] a);
    if (zr(k) && a == 4'd0) return 32'h0;
    if (bp(k) && write && rd == a) return in1;
    return m_regs[k][a];
  endfunction

  function automatic bit m_stall(input int k);
    return enable && read && (m_blocked(k, rs) || m_blocked(k, rt));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 16; r++) m_regs[k][r] = 32'h0;
      m_busy[k] = 16'h0;
      m_o1[k]   = 32'h0;
      m_o2[k]   = 32'h0;
      m_v[k]    = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit s;
      s = m_stall(k);
      if (!enable) begin
        m_v[k] = 1'b0;
      end else begin
        if (read && !s) begin
          m_o1[k] = m_value(k, rs);
          m_o2[k] = m_value(k, rt);
          m_v[k]  = 1'b1;
        end else begin
          m_v[k] = 1'b0;
        end
        if (write && !(zr(k) && rd == 4'd0)) m_regs[k][rd] = in1;
        if (write) m_busy[k][rd] = 1'b0;
        if (reserve && !(zr(k) && rsv_addr == 4'd0)) m_busy[k][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out1[%0d]", k), o1[k], m_o1[k]);
      chk($sformatf("out2[%0d]", k), o2[k], m_o2[k]);
      chk($sformatf("rd_valid[%0d]", k), 32'(v[k]), 32'(m_v[k]));
      chk($sformatf("busy[%0d]", k), 32'(bz[k]), 32'(m_busy[k]));
      chk($sformatf("tap_out[%0d]", k), 32'(tp0[k]), 32'(m_regs[k][10][7:0]));
      chk($sformatf("tap_outt[%0d]", k), 32'(tp1[k]), 32'(m_regs[k][3][7:0]));
    end
  endtask

  // One clock: check combinational and registered outputs mid-cycle, then advance the model.
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      last_st[k] = st[k];
      chk($sformatf("rd_stall[%0d]", k), 32'(st[k]), 32'(m_stall(k)));
    end
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic en, input logic rdq, input logic [3:0] a_rs, input logic [3:0] a_rt,
                       input logic wr, input logic [3:0] a_rd, input logic [31:0] d,
                       input logic rsv, input logic [3:0] a_rsv);
    enable = en; read = rdq; rs = a_rs; rt = a_rt;
    write = wr; rd = a_rd; in1 = d; reserve = rsv; rsv_addr = a_rsv;
  endtask

  typedef struct {
    logic        en;
    logic        rdq;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        wr;
    logic [3:0]  rd;
    logic [31:0] din;
    logic        rsv;
    logic [3:0]  ra;
    logic        exp_st;
    logic [31:0] exp_o1;
    logic        exp_v;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 4'd10, 4'd3, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 32'h0,        1'b1};
    tbl[1]  = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 4'd5,  32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b1, 1'b1, 4'd5,  4'd5, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 32'hDEADBEEF, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 4'd10, 32'h123456A5, 1'b0, 4'd0, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b0, 4'd0,  32'h0,        1'b1, 4'd7, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'd7,  4'd7, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 4'd7,  4'd7, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 4'd7,  4'd7, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'd7,  4'd7, 1'b1, 4'd7,  32'h55,       1'b0, 4'd0, 1'b0, 32'h55,       1'b1};
    tbl[9]  = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 4'd4,  32'h11,       1'b1, 4'd4, 1'b0, 32'h55,       1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'd4,  4'd0, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b1, 32'h55,       1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'd0,  4'd0, 1'b1, 4'd4,  32'h22,       1'b0, 4'd0, 1'b0, 32'h55,       1'b0};
    tbl[12] = '{1'b1, 1'b1, 4'd4,  4'd4, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 32'h22,       1'b1};
    tbl[13] = '{1'b0, 1'b1, 4'd5,  4'd5, 1'b0, 4'd0,  32'h0,        1'b0, 4'd0, 1'b0, 32'h22,       1'b0};

    reset_all = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset_all = 1'b0;

    // Directed vectors for the default configuration.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].rdq, tbl[i].rs, tbl[i].rt, tbl[i].wr, tbl[i].rd,
            tbl[i].din, tbl[i].rsv, tbl[i].ra);
      cycle();
      chk($sformatf("tbl%0d_stall", i), 32'(last_st[0]), 32'(tbl[i].exp_st));
      chk($sformatf("tbl%0d_out1", i), o1[0], tbl[i].exp_o1);
      chk($sformatf("tbl%0d_valid", i), 32'(v[0]), 32'(tbl[i].exp_v));
      if (i == 3) chk("tap_A5", 32'(tp0[0]), 32'h000000A5);
      if (i == 9) chk("busy4_after_wr_rsv", 32'(bz[0][4]), 32'h1);
    end

    // Clearing write coinciding with the read: forwarded vs one extra stall.
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd9);
    cycle();
    drive(1'b1, 1'b1, 4'd9, 4'd9, 1'b1, 4'd9, 32'h77, 1'b0, 4'd0);
    cycle();
    chk("nb_stall_on_clear", 32'(last_st[1]), 32'h1);
    chk("bp_no_stall_on_clear", 32'(last_st[0]), 32'h0);
    chk("bp_forward", o1[0], 32'h77);
    chk("nb_valid_low", 32'(v[1]), 32'h0);
    drive(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    cycle();
    chk("nb_retry_no_stall", 32'(last_st[1]), 32'h0);
    chk("nb_retry_data", o1[1], 32'h77);
    chk("nb_retry_valid", 32'(v[1]), 32'h1);

    // Hard-wired R0: write and reserve ignored.
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFF, 1'b1, 4'd0);
    cycle();
    chk("zr_busy0", 32'(bz[2][0]), 32'h0);
    chk("plain_busy0", 32'(bz[0][0]), 32'h1);
    drive(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    cycle();
    chk("zr_r0_no_stall", 32'(last_st[2]), 32'h0);
    chk("zr_r0_data", o1[2], 32'h0);
    chk("zr_r0_valid", 32'(v[2]), 32'h1);
    chk("plain_r0_stall", 32'(last_st[0]), 32'h1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      enable   = ($urandom_range(0, 9) != 0);
      read     = 1'($urandom_range(0, 1));
      rs       = 4'($urandom_range(0, 15));
      rt       = 4'($urandom_range(0, 15));
      write    = ($urandom_range(0, 2) != 0);
      rd       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rd = rs;
      in1      = $urandom;
      reserve  = ($urandom_range(0, 3) == 0);
      rsv_addr = 4'($urandom_range(0, 15));
      cycle();
    end

    // Reset while a read is stalled.
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b1, 4'd2);
    cycle();
    drive(1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    cycle();
    chk("pre_reset_stall", 32'(last_st[0]), 32'h1);
    reset_all = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("reset_clears_stall", 32'(st[0]), 32'h0);
    @(posedge clk);
    #1;
    reset_all = 1'b0;
    cycle();
    chk("post_reset_data", o1[0], 32'h0);
    chk("post_reset_valid", 32'(v[0]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
